// File: rtl/intan_ring_pkg.sv
// Shared state encoding and default geometry for the acquisition BRAM ring controller.
package intan_ring_pkg;

    localparam int DEF_ADDR_W       = 14;
    localparam int DEF_DEPTH_WORDS  = 16384;
    localparam int DEF_PACKET_WORDS = 144;
    localparam int DEF_RESUME_WORDS = 288;

    // State field codes as seen in the status register
    localparam logic [2:0] STATE_CODE_IDLE  = 3'd0;
    localparam logic [2:0] STATE_CODE_RUN   = 3'd1;
    localparam logic [2:0] STATE_CODE_HOLD  = 3'd2;
    localparam logic [2:0] STATE_CODE_DRAIN = 3'd3;
    localparam logic [2:0] STATE_CODE_FAULT = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = STATE_CODE_IDLE,
        ST_RUN   = STATE_CODE_RUN,
        ST_HOLD  = STATE_CODE_HOLD,
        ST_DRAIN = STATE_CODE_DRAIN,
        ST_FAULT = STATE_CODE_FAULT
    } ring_state_e;

endpackage

// File: rtl/bram_ring_controller_if.sv
// Control/status bundle between the register bank, generator, FIFO-BRAM path and the ring controller.
interface bram_ring_controller_if #(
    parameter int ADDR_W = 14
);
    logic              start;
    logic              stop;
    logic              clear;
    logic              wr_commit;
    logic              pkt_done;
    logic              ack_valid;
    logic [ADDR_W:0]   ack_words;
    logic [ADDR_W:0]   irq_threshold;

    logic              gen_enable;
    logic [2:0]        state;
    logic [ADDR_W:0]   occupancy;
    logic [ADDR_W-1:0] rd_ptr;
    logic              irq;
    logic              overflow;
    logic              ack_error;
    logic [31:0]       pkt_count;
    logic [ADDR_W:0]   high_water;

    modport master (
        output start, stop, clear, wr_commit, pkt_done, ack_valid, ack_words, irq_threshold,
        input  gen_enable, state, occupancy, rd_ptr, irq, overflow, ack_error, pkt_count, high_water
    );

    modport slave (
        input  start, stop, clear, wr_commit, pkt_done, ack_valid, ack_words, irq_threshold,
        output gen_enable, state, occupancy, rd_ptr, irq, overflow, ack_error, pkt_count, high_water
    );

endinterface

// File: rtl/ring_occupancy_tracker.sv
// Ring occupancy arithmetic: netting of commits and acks, clamping, overflow, rd_ptr wrap.
// High-water tracking is built only when BRAM_RING_CTRL_WATERMARK_EN is defined.
module ring_occupancy_tracker #(
    parameter int ADDR_W      = 14,
    parameter int DEPTH_WORDS = 16384
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear_en,
    input  logic              wr_commit,
    input  logic              ack_valid,
    input  logic [ADDR_W:0]   ack_words,
    input  logic [ADDR_W:0]   irq_threshold,
    output logic [ADDR_W:0]   occupancy,
    output logic [ADDR_W:0]   occupancy_next,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              ack_error,
    output logic              overflow,
    output logic [ADDR_W:0]   high_water,
    output logic              ovf_event,
    output logic              thr_cross
);

    // Two spare bits: occupancy + commit can reach DEPTH+1, rd_ptr + release up to 2*DEPTH
    localparam int CW = ADDR_W + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH_WORDS);

    logic [CW-1:0] sum;
    logic [CW-1:0] ack_ext;
    logic [CW-1:0] applied;
    logic [CW-1:0] net;
    logic [CW-1:0] occ_sat;
    logic [CW-1:0] rel_mod;
    logic [CW-1:0] ptr_sum;
    logic [CW-1:0] ptr_next;
    logic          under;

    always_comb begin
        sum     = {1'b0, occupancy} + CW'(wr_commit);
        ack_ext = {1'b0, ack_words};
        applied = '0;
        under   = 1'b0;
        if (ack_valid) begin
            if (ack_ext > sum) begin
                applied = sum;
                under   = 1'b1;
            end else begin
                applied = ack_ext;
            end
        end
        net       = sum - applied;
        ovf_event = (net > DEPTH_C);
        occ_sat   = ovf_event ? DEPTH_C : net;
        // A release can exceed DEPTH by at most one word, so one pre-fold keeps the wrap to a single subtract
        rel_mod   = (applied >= DEPTH_C) ? (applied - DEPTH_C) : applied;
        ptr_sum   = {2'b00, rd_ptr} + rel_mod;
        ptr_next  = (ptr_sum >= DEPTH_C) ? (ptr_sum - DEPTH_C) : ptr_sum;
    end

    assign occupancy_next = (ADDR_W + 1)'(occ_sat);
    assign thr_cross      = (irq_threshold != '0) && (occupancy < irq_threshold)
                            && (occupancy_next >= irq_threshold);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occupancy <= '0;
            rd_ptr    <= '0;
            ack_error <= 1'b0;
            overflow  <= 1'b0;
        end else if (clear_en) begin
            occupancy <= '0;
            rd_ptr    <= '0;
            ack_error <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            occupancy <= occupancy_next;
            rd_ptr    <= ADDR_W'(ptr_next);
            if (under) begin
                ack_error <= 1'b1;
            end
            if (ovf_event) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef BRAM_RING_CTRL_WATERMARK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            high_water <= '0;
        end else if (clear_en) begin
            high_water <= '0;
        end else if (occupancy_next > high_water) begin
            high_water <= occupancy_next;
        end
    end
`else
    assign high_water = '0;
`endif

endmodule

// File: rtl/bram_ring_controller.sv
// Acquisition ring sequencer: gates the data generator on packet boundaries and
// pauses it before the BRAM ring can overrun. Watermark via BRAM_RING_CTRL_WATERMARK_EN.
//
//   state | meaning
//   IDLE  | generator off, waiting for start
//   RUN   | generator on, packets flowing into the ring
//   HOLD  | generator paused until RESUME_WORDS are free
//   DRAIN | stop requested, generator finishes current packet
//   FAULT | write committed into a full ring; only clear leaves
module bram_ring_controller
    import intan_ring_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DEPTH_WORDS  = DEF_DEPTH_WORDS,
    parameter int PACKET_WORDS = DEF_PACKET_WORDS,
    parameter int RESUME_WORDS = DEF_RESUME_WORDS
) (
    input logic                   clk,
    input logic                   rstn,
    bram_ring_controller_if.slave bus
);

    localparam int CW = ADDR_W + 2;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH_WORDS);
    localparam logic [CW-1:0] PACKET_C = CW'(PACKET_WORDS);
    localparam logic [CW-1:0] RESUME_C = CW'(RESUME_WORDS);

    ring_state_e     state_q;
    ring_state_e     state_d;
    logic            gen_enable_q;
    logic            gen_enable_d;
    logic            irq_q;
    logic            irq_d;
    logic            pkt_inc;
    logic [31:0]     pkt_count_q;
    logic            clear_en;
    logic            ovf_event;
    logic            thr_cross;
    logic [ADDR_W:0] occupancy;
    logic [ADDR_W:0] occupancy_next;
    logic [CW-1:0]   free_now;
    logic [CW-1:0]   free_next;

    assign clear_en  = bus.clear && ((state_q == ST_IDLE) || (state_q == ST_FAULT));
    assign free_now  = DEPTH_C - {1'b0, occupancy};
    assign free_next = DEPTH_C - {1'b0, occupancy_next};

    ring_occupancy_tracker #(
        .ADDR_W        (ADDR_W),
        .DEPTH_WORDS   (DEPTH_WORDS)
    ) u_tracker (
        .clk           (clk),
        .rstn          (rstn),
        .clear_en      (clear_en),
        .wr_commit     (bus.wr_commit),
        .ack_valid     (bus.ack_valid),
        .ack_words     (bus.ack_words),
        .irq_threshold (bus.irq_threshold),
        .occupancy     (occupancy),
        .occupancy_next(occupancy_next),
        .rd_ptr        (bus.rd_ptr),
        .ack_error     (bus.ack_error),
        .overflow      (bus.overflow),
        .high_water    (bus.high_water),
        .ovf_event     (ovf_event),
        .thr_cross     (thr_cross)
    );

    always_comb begin
        state_d = state_q;
        pkt_inc = bus.pkt_done && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
        if (clear_en) begin
            state_d = ST_IDLE;
        end else if (ovf_event) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A stop coinciding with pkt_done is already on the packet boundary
                    if (bus.stop) begin
                        state_d = bus.pkt_done ? ST_IDLE : ST_DRAIN;
                    end else if (bus.pkt_done && (free_next < PACKET_C)) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.stop) begin
                        state_d = ST_IDLE;
                    end else if (free_now >= RESUME_C) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.pkt_done) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase
        end
        gen_enable_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        irq_d        = !clear_en && (thr_cross || (ovf_event && (state_q != ST_FAULT)));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            gen_enable_q <= 1'b0;
            irq_q        <= 1'b0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            gen_enable_q <= gen_enable_d;
            irq_q        <= irq_d;
            if (clear_en) begin
                pkt_count_q <= '0;
            end else if (pkt_inc) begin
                pkt_count_q <= pkt_count_q + 32'd1;
            end
        end
    end

    assign bus.state      = state_q;
    assign bus.gen_enable = gen_enable_q;
    assign bus.irq        = irq_q;
    assign bus.pkt_count  = pkt_count_q;
    assign bus.occupancy  = occupancy;

endmodule

// File: tb/tb_bram_ring_controller.sv
// Bench for bram_ring_controller: two ring geometries (512 and 300 words) driven in lockstep
// against a behavioural model, plus directed checks of the sequencing scenarios.
module tb_bram_ring_controller;

    localparam int AW      = 9;
    localparam int PKT     = 144;
    localparam int RES     = 288;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_HOLD  = 2;
    localparam int S_DRAIN = 3;
    localparam int S_FAULT = 4;

    logic        clk       = 1'b0;
    logic        rstn      = 1'b1;
    logic        start     = 1'b0;
    logic        stop      = 1'b0;
    logic        clear     = 1'b0;
    logic        wr_commit = 1'b0;
    logic        pkt_done  = 1'b0;
    logic        ack_valid = 1'b0;
    logic [AW:0] ack_words = '0;
    logic [AW:0] thr       = '0;

    int n_assert = 0;
    int n_fail   = 0;

    int          m_occ [2];
    int          m_rd  [2];
    int          m_st  [2];
    int          m_hw  [2];
    bit          m_gen [2];
    bit          m_irq [2];
    bit          m_ovf [2];
    bit          m_aerr[2];
    logic [31:0] m_pkt [2];

    always #5 clk = ~clk;

    bram_ring_controller_if #(.ADDR_W(AW)) if_a ();
    bram_ring_controller_if #(.ADDR_W(AW)) if_b ();

    assign if_a.start = start;           assign if_b.start = start;
    assign if_a.stop = stop;             assign if_b.stop = stop;
    assign if_a.clear = clear;           assign if_b.clear = clear;
    assign if_a.wr_commit = wr_commit;   assign if_b.wr_commit = wr_commit;
    assign if_a.pkt_done = pkt_done;     assign if_b.pkt_done = pkt_done;
    assign if_a.ack_valid = ack_valid;   assign if_b.ack_valid = ack_valid;
    assign if_a.ack_words = ack_words;   assign if_b.ack_words = ack_words;
    assign if_a.irq_threshold = thr;     assign if_b.irq_threshold = thr;

    bram_ring_controller #(.ADDR_W(AW), .DEPTH_WORDS(512), .PACKET_WORDS(PKT), .RESUME_WORDS(RES))
        u_dut_a (.clk(clk), .rstn(rstn), .bus(if_a));
    bram_ring_controller #(.ADDR_W(AW), .DEPTH_WORDS(300), .PACKET_WORDS(PKT), .RESUME_WORDS(RES))
        u_dut_b (.clk(clk), .rstn(rstn), .bus(if_b));

    function automatic int dep(input int i);
        return (i == 0) ? 512 : 300;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_occ[i] = 0; m_rd[i] = 0; m_st[i] = S_IDLE; m_hw[i] = 0;
            m_gen[i] = 0; m_irq[i] = 0; m_ovf[i] = 0; m_aerr[i] = 0; m_pkt[i] = '0;
        end
    endtask

    // Applies one clock's worth of inputs to the model of each ring geometry
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int d, st, ns, total, rel, nxt;
            bit ovf_ev;
            d  = dep(i);
            st = m_st[i];
            if (clear && (st == S_IDLE || st == S_FAULT)) begin
                m_occ[i] = 0; m_rd[i] = 0; m_st[i] = S_IDLE; m_hw[i] = 0;
                m_gen[i] = 0; m_irq[i] = 0; m_ovf[i] = 0; m_aerr[i] = 0; m_pkt[i] = '0;
                continue;
            end
            total = m_occ[i] + (wr_commit ? 1 : 0);
            rel   = 0;
            if (ack_valid) begin
                if (int'(ack_words) > total) begin
                    rel = total;
                    m_aerr[i] = 1;
                end else begin
                    rel = int'(ack_words);
                end
            end
            nxt    = total - rel;
            ovf_ev = (nxt > d);
            if (ovf_ev) nxt = d;
            m_irq[i] = (thr != 0) && (m_occ[i] < int'(thr)) && (nxt >= int'(thr));
            ns = st;
            if (ovf_ev) begin
                ns = S_FAULT;
                if (st != S_FAULT) m_irq[i] = 1;
            end else if (st == S_IDLE) begin
                if (start && !stop) ns = S_RUN;
            end else if (st == S_RUN) begin
                if (stop) ns = pkt_done ? S_IDLE : S_DRAIN;
                else if (pkt_done && (d - nxt) < PKT) ns = S_HOLD;
            end else if (st == S_HOLD) begin
                if (stop) ns = S_IDLE;
                else if ((d - m_occ[i]) >= RES) ns = S_RUN;
            end else if (st == S_DRAIN) begin
                if (pkt_done) ns = S_IDLE;
            end
            if (pkt_done && (st == S_RUN || st == S_DRAIN)) m_pkt[i] = m_pkt[i] + 1;
            if (ovf_ev) m_ovf[i] = 1;
`ifdef BRAM_RING_CTRL_WATERMARK_EN
            if (nxt > m_hw[i]) m_hw[i] = nxt;
`endif
            m_rd[i]  = (m_rd[i] + rel) % d;
            m_occ[i] = nxt;
            m_st[i]  = ns;
            m_gen[i] = (ns == S_RUN) || (ns == S_DRAIN);
        end
    endtask

    task automatic check_inst(input string n, input int i, input logic gen, input logic [2:0] st,
                              input logic [AW:0] occ, input logic [AW-1:0] rd, input logic irq,
                              input logic ovf, input logic aerr, input logic [31:0] pkt,
                              input logic [AW:0] hw);
        chk({n, ".gen_enable"}, 32'(gen),  32'(m_gen[i]));
        chk({n, ".state"},      32'(st),   32'(m_st[i]));
        chk({n, ".occupancy"},  32'(occ),  32'(m_occ[i]));
        chk({n, ".rd_ptr"},     32'(rd),   32'(m_rd[i]));
        chk({n, ".irq"},        32'(irq),  32'(m_irq[i]));
        chk({n, ".overflow"},   32'(ovf),  32'(m_ovf[i]));
        chk({n, ".ack_error"},  32'(aerr), 32'(m_aerr[i]));
        chk({n, ".pkt_count"},  pkt,       m_pkt[i]);
        chk({n, ".high_water"}, 32'(hw),   32'(m_hw[i]));
    endtask

    task automatic check_all();
        check_inst("a", 0, if_a.gen_enable, if_a.state, if_a.occupancy, if_a.rd_ptr, if_a.irq,
                   if_a.overflow, if_a.ack_error, if_a.pkt_count, if_a.high_water);
        check_inst("b", 1, if_b.gen_enable, if_b.state, if_b.occupancy, if_b.rd_ptr, if_b.irq,
                   if_b.overflow, if_b.ack_error, if_b.pkt_count, if_b.high_water);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        start = 0; stop = 0; clear = 0; wr_commit = 0; pkt_done = 0; ack_valid = 0; ack_words = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic commits(input int n);
        for (int k = 0; k < n; k++) begin
            wr_commit = 1;
            cycle();
        end
    endtask

    task automatic ack(input int w);
        ack_valid = 1;
        ack_words = (AW + 1)'(w);
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int irq_n, irq_at;
        int rates[3];
        rates[0] = 80; rates[1] = 4; rates[2] = 6;
        #1;

        // Basic run: gen_enable the cycle after start, one packet counted
        do_reset();
        start = 1; cycle();
        chk("t1.gen_after_start", 32'(if_a.gen_enable), 32'd1);
        commits(PKT);
        pkt_done = 1; cycle();
        chk("t1.occupancy", 32'(if_a.occupancy), 32'd144);
        chk("t1.pkt_count", if_a.pkt_count, 32'd1);
        chk("t1.state", 32'(if_a.state), 32'(S_RUN));

        // Back-pressure: 3rd packet leaves 80 free on 512 words, 208-word ack frees 288
        do_reset();
        start = 1; cycle();
        for (int p = 0; p < 3; p++) begin
            commits(PKT);
            pkt_done = 1; cycle();
        end
        chk("t2.state_hold", 32'(if_a.state), 32'(S_HOLD));
        chk("t2.gen_hold", 32'(if_a.gen_enable), 32'd0);
        ack(208);
        chk("t2.occ_after_ack", 32'(if_a.occupancy), 32'd224);
        cycle();
        chk("t2.state_resume", 32'(if_a.state), 32'(S_RUN));
        chk("t2.gen_resume", 32'(if_a.gen_enable), 32'd1);

        // Threshold interrupt: exactly one pulse, observed after the 100th commit
        do_reset();
        thr = (AW + 1)'(100);
        irq_n = 0; irq_at = -1;
        for (int k = 1; k <= PKT; k++) begin
            wr_commit = 1; cycle();
            if (if_a.irq === 1'b1) begin
                irq_n++;
                irq_at = k;
            end
        end
        chk("t3.irq_pulses", 32'(irq_n), 32'd1);
        chk("t3.irq_commit_index", 32'(irq_at), 32'd100);
        thr = '0;

        // Pointer wrap on the 300-word ring
        do_reset();
        commits(250);
        ack(250);
        chk("t4.rd_ptr_b_250", 32'(if_b.rd_ptr), 32'd250);
        commits(100);
        ack(100);
        chk("t4.rd_ptr_b_wrap", 32'(if_b.rd_ptr), 32'd50);
        chk("t4.rd_ptr_a", 32'(if_a.rd_ptr), 32'd350);

        // Over-acknowledge clamps to zero and latches ack_error
        do_reset();
        commits(200);
        ack(500);
        chk("t5.occ_clamp", 32'(if_a.occupancy), 32'd0);
        chk("t5.ack_error", 32'(if_a.ack_error), 32'd1);

        // Overrun: FAULT with one irq, start ignored, clear restores all-zero outputs
        do_reset();
        start = 1; cycle();
        commits(512);
        chk("t6.full_occ", 32'(if_a.occupancy), 32'd512);
        chk("t6.full_no_ovf", 32'(if_a.overflow), 32'd0);
        commits(1);
        chk("t6.overflow", 32'(if_a.overflow), 32'd1);
        chk("t6.state_fault", 32'(if_a.state), 32'(S_FAULT));
        chk("t6.gen_fault", 32'(if_a.gen_enable), 32'd0);
        chk("t6.irq_fault", 32'(if_a.irq), 32'd1);
        cycle();
        chk("t6.irq_one_cycle", 32'(if_a.irq), 32'd0);
        start = 1; cycle();
        chk("t6.start_ignored", 32'(if_a.state), 32'(S_FAULT));
        clear = 1; cycle();
        chk("t6.clr_state", 32'(if_a.state), 32'(S_IDLE));
        chk("t6.clr_occ", 32'(if_a.occupancy), 32'd0);
        chk("t6.clr_ovf", 32'(if_a.overflow), 32'd0);
        chk("t6.clr_rd_ptr", 32'(if_a.rd_ptr), 32'd0);

        // Drain on stop, start ignored while draining, start+stop in IDLE stays IDLE
        do_reset();
        start = 1; cycle();
        commits(50);
        stop = 1; cycle();
        chk("t7.state_drain", 32'(if_a.state), 32'(S_DRAIN));
        start = 1; cycle();
        commits(20);
        chk("t7.gen_drain", 32'(if_a.gen_enable), 32'd1);
        pkt_done = 1; cycle();
        chk("t7.state_idle", 32'(if_a.state), 32'(S_IDLE));
        chk("t7.gen_off", 32'(if_a.gen_enable), 32'd0);
        start = 1; stop = 1; cycle();
        chk("t7.start_stop_idle", 32'(if_a.state), 32'(S_IDLE));
        start = 1; cycle();
        clear = 1; cycle();
        chk("t7.clear_in_run", 32'(if_a.state), 32'(S_RUN));

        // Randomized traffic at three release rates, with one mid-run reset
        for (int ph = 0; ph < 3; ph++) begin
            do_reset();
            for (int c = 0; c < 1200; c++) begin
                if (ph == 2 && c == 600) do_reset();
                start     = ($urandom_range(99) < 4);
                stop      = ($urandom_range(99) < 2);
                clear     = ($urandom_range(99) < 2);
                wr_commit = ($urandom_range(99) < 70);
                pkt_done  = ($urandom_range(99) < 3);
                ack_valid = ($urandom_range(999) < rates[ph]);
                ack_words = (AW + 1)'($urandom_range(240));
                if ($urandom_range(299) == 0) thr = (AW + 1)'($urandom_range(400));
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_ring_controller.md
# bram_ring_controller

Sequencing and flow-control controller for the acquisition BRAM ring buffer. It starts and stops the data generator core on packet boundaries and tracks ring occupancy from FIFO-to-BRAM write commits and host read acknowledgements. It pauses generation before the ring can overrun, raises a threshold interrupt and flags overflow. It sits between the control/status register bank, the data generator core (enable, packet-done) and the FIFO-BRAM interface (write commit).

## Interface
- ADDR_W, 14, ring word-address width
- DEPTH_WORDS, 16384, ring depth in 32-bit words; must be ≤ 2^ADDR_W, need not be a power of two
- PACKET_WORDS, 144, words per generator packet
- RESUME_WORDS, 288, free words required to leave HOLD; must be ≥ PACKET_WORDS
- clk  in  1  system clock
- rstn  in  1  reset; asynchronous, active-low
- start  in  1  pulse: begin acquisition
- stop  in  1  pulse: end acquisition at next packet boundary
- clear  in  1  pulse: clear occupancy, pointers, flags and counters (IDLE/FAULT only)
- wr_commit  in  1  pulse: one word written into BRAM
- pkt_done  in  1  pulse: generator finished a packet (last word handed to FIFO)
- ack_valid  in  1  pulse: host consumed ack_words words
- ack_words  in  ADDR_W+1  words released by host
- irq_threshold  in  ADDR_W+1  occupancy interrupt threshold; 0 disables
- gen_enable  out  1  enable to data generator core
- state  out  3  IDLE=0, RUN=1, HOLD=2, DRAIN=3, FAULT=4
- occupancy  out  ADDR_W+1  words written but not yet acknowledged
- rd_ptr  out  ADDR_W  next word index for host to read
- irq  out  1  one-cycle interrupt pulse
- overflow  out  1  sticky: write commit while ring full
- ack_error  out  1  sticky: ack_words exceeded occupancy
- pkt_count  out  32  packets completed since clear; wraps
- high_water  out  ADDR_W+1  maximum occupancy since clear (see Configuration)

## Operation
- All outputs are registered. Reset and clear values are 0 for every output, so state is IDLE.
- IDLE: gen_enable=0.
  - start → RUN.
  - start and stop in the same cycle: stop wins, stay IDLE.
- RUN: gen_enable=1.
  - stop → DRAIN.
  - On pkt_done, if DEPTH_WORDS − occupancy_next < PACKET_WORDS → HOLD.
- HOLD: gen_enable=0.
  - stop → IDLE.
  - When DEPTH_WORDS − occupancy ≥ RESUME_WORDS → RUN.
- DRAIN: gen_enable=1 until pkt_done, then IDLE. A start in DRAIN is ignored.
- FAULT: entered from any state on overflow. gen_enable=0. Only clear leaves it (→ IDLE). start and stop are ignored.
- Occupancy update each cycle: occupancy_next = occupancy + wr_commit − (ack_valid ? ack_words : 0).
  - If the subtraction would go below 0, clamp to 0 and set ack_error.
  - wr_commit while occupancy == DEPTH_WORDS (net of a same-cycle ack): occupancy holds at DEPTH_WORDS, overflow set, → FAULT.
- rd_ptr advances by the applied release amount, modulo DEPTH_WORDS, using compare-and-subtract wrap. No power-of-two assumption.
- irq is a one-cycle pulse in two cases:
  - occupancy crosses irq_threshold upward (occupancy < thr and occupancy_next ≥ thr, thr≠0);
  - the cycle of entry into FAULT.
- pkt_count increments on pkt_done in RUN or DRAIN. pkt_done in IDLE, HOLD or FAULT is ignored.
- clear in RUN, HOLD or DRAIN is ignored.

## Timing
- gen_enable, state, irq: change on the clock edge after the triggering input.
- Examples: pkt_done at cycle n → gen_enable=0 at n+1; start at n → gen_enable=1 at n+1.
- occupancy and rd_ptr reflect inputs from cycle n at cycle n+1.
- wr_commit and ack_valid in the same cycle are netted in a single update.
- Asynchronous reset mid-packet drops to IDLE immediately. No drain is performed.

## Configuration
- BRAM_RING_CTRL_WATERMARK_EN defined: high_water register tracks max(occupancy) and is cleared by clear and reset.
- Not defined: high_water is tied to 0 and no register is synthesized.

## Structure
- Shared package intan_ring_pkg holds:
  - the state enumeration (3-bit encodings above);
  - state code localparams for the status register mapping;
  - the default ADDR_W, DEPTH_WORDS and PACKET_WORDS constants.
- One sub-module, ring_occupancy_tracker, handles the occupancy arithmetic, clamping, overflow detection, rd_ptr wrap and watermark.
- The state machine stays in bram_ring_controller.

## Test plan
- Reset, then start, 144 wr_commit, pkt_done → gen_enable=1 from the cycle after start; occupancy=144; pkt_count=1; state RUN.
- DEPTH_WORDS=512, no acks, three packets → HOLD after the 3rd pkt_done (free 80 < 144); ack 208 words → RUN (free 288).
- irq_threshold=100, 144 commits → exactly one irq pulse, in the cycle after the 100th commit.
- DEPTH_WORDS=300, rd_ptr=250, ack 100 → rd_ptr=50. In a separate case, ack 500 with occupancy 200 → occupancy=0 and ack_error=1.
- Ring full with wr_commit pulsed → overflow=1, state FAULT, gen_enable=0, one irq pulse; start ignored; clear → IDLE with all outputs 0.
- stop mid-packet in RUN → DRAIN, gen_enable stays 1 until pkt_done, then 0 with state IDLE. Simultaneous start and stop in IDLE → remains IDLE.
